comp_feeder: RTL
================

// Module: comp_feeder
// PURPOSE
// - Initiator side of the comp_layer comparator interface (load, d1_num/d1, d2_num/d2 -> q_num/q).
// - Captures NUM_CLASS signed class scores on start and drives one external registered 2-input max
//   comparator. The comparator's q/q_num is fed back each cycle to form a sequential argmax.
// - Returns the winning class index and value with a one-cycle done pulse; sits at the network output.
// PARAMETERS
// - DATA_LEN   16  score width in bits, signed two's complement
// - NUM_CLASS  10  number of scores; legal range 2..16 (index is 4 bits)
// PORTS
// - clk         in   1                   clock, rising edge
// - rst_n       in   1                   asynchronous, active-low reset
// - start       in   1                   request; sampled only in IDLE
// - scores      in   NUM_CLASS*DATA_LEN  flat score vector; score k = scores[k*DATA_LEN +: DATA_LEN]
// - busy        out  1                   high whenever state != IDLE
// - load        out  1                   comparator load enable
// - d1_num      out  4                   comparator operand 1 index
// - d1          out  DATA_LEN            comparator operand 1 value, signed
// - d2_num      out  4                   comparator operand 2 index
// - d2          out  DATA_LEN            comparator operand 2 value, signed
// - q_num       in   4                   comparator registered result index
// - q           in   DATA_LEN            comparator registered result value, signed
// - done        out  1                   one-cycle pulse: result valid
// - result_num  out  4                   argmax index, held until next done
// - result      out  DATA_LEN            max score, signed, held until next done
// BEHAVIOUR
// - Reset: state=IDLE, idx=0, score register=0, done=0, result_num=0, result=0.
//   Combinational outputs under reset: busy=0, load=0, d1/d2/d1_num/d2_num=0.
// - States: IDLE, RUN, FINISH.
// - IDLE: if start=1 at a rising edge, capture scores into an internal register, set idx=1, go RUN.
//   start=0 keeps the state in IDLE. start is ignored in RUN and FINISH; a request is never queued.
// - RUN: load=1 (combinational from state).
//   - d2=score[idx], d2_num=idx.
//   - If idx==1: d1=score[0], d1_num=0. Otherwise d1=q, d1_num=q_num.
//   - Each edge: idx<=idx+1. When idx==NUM_CLASS-1 at the edge, go FINISH.
//   - RUN always issues exactly NUM_CLASS-1 loads, one per cycle, with no gaps.
// - FINISH: load=0. At the edge: result<=q, result_num<=q_num, done<=1, go IDLE.
// - done: registered; high exactly one cycle; cleared on the next edge.
// - Latency: start accepted at edge E0 -> done high in the cycle after edge E(NUM_CLASS).
//   New start accepted at the edge where done is high (state is IDLE then).
// - Ties: the comparator selects d2 unless d1>d2 strictly, so the highest index among equal maxima wins.
// - Arithmetic: all comparisons are signed. No widening and no saturation; values pass through unchanged.
// - Boundary: NUM_CLASS=2 -> a single RUN cycle with idx==1; the FINISH path is taken directly.
// - Mid-operation: scores changing after capture has no effect on the current run.
//   rst_n low in any state -> immediate IDLE, no done pulse; the run in progress is discarded.
// - The comparator shares clk/rst_n and must have exactly one cycle of load-to-q latency.
// CONFIGURATION
// - FEEDER_ABORT_EN defined: adds input port abort (1 bit).
//   - abort=1 at an edge in RUN or FINISH -> IDLE, load drops next cycle.
//   - On abort: no done pulse; result/result_num keep their previous values.
//   - abort has priority over the FINISH capture; abort in IDLE is ignored.
// - FEEDER_ABORT_EN undefined: no abort port; every accepted start produces exactly one done.
// TESTING
// - NUM_CLASS=10, scores 0..9 = {3,-7,12,5,0,12,-1,8,2,4}, start 1 cycle ->
//   9 consecutive loads, done 10 cycles after start, result_num=5, result=12 (tie, higher index wins).
// - All scores negative {-5,-2,-9,-2,-30,-8,-4,-6,-3,-7} -> result_num=3, result=-2 (signed compare).
// - Max at index 0: score0=32767, rest=-32768 -> result_num=0, result=32767.
//   d1 tracks q from the second load onward.
// - start held high continuously ->
//   back-to-back runs, one done per run, busy low only in the done cycle, no extra loads.
// - rst_n low during the 4th RUN cycle ->
//   busy=0, load=0, done never pulses; a new start gives the correct result.
// - FEEDER_ABORT_EN: abort in the 3rd RUN cycle -> IDLE next cycle, no done,
//   result keeps the previous run's value. NUM_CLASS=2 build: scores {1,1} -> result_num=1.

Source files
------------

// File: rtl/comp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : comp_feeder
// Purpose  : Sequential argmax of NUM_CLASS signed scores. It drives an external
//            registered max comparator and feeds the comparator result back.
//            Optional abort input is enabled by defining FEEDER_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module comp_feeder #(
    parameter int DATA_LEN  = 16,
    parameter int NUM_CLASS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef FEEDER_ABORT_EN
    input  logic                          abort,
`endif
    input  logic                          start,
    input  logic [NUM_CLASS*DATA_LEN-1:0] scores,
    output logic                          busy,
    output logic                          load,
    output logic [3:0]                    d1_num,
    output logic signed [DATA_LEN-1:0]    d1,
    output logic [3:0]                    d2_num,
    output logic signed [DATA_LEN-1:0]    d2,
    input  logic [3:0]                    q_num,
    input  logic signed [DATA_LEN-1:0]    q,
    output logic                          done,
    output logic [3:0]                    result_num,
    output logic signed [DATA_LEN-1:0]    result
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_IDX = 4'(NUM_CLASS - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [3:0]                 r_idx;
    logic signed [DATA_LEN-1:0] r_score [NUM_CLASS];
    logic signed [DATA_LEN-1:0] w_sel;
    logic                       r_done;
    logic [3:0]                 r_result_num;
    logic signed [DATA_LEN-1:0] r_result;
    logic                       w_abort;

`ifdef FEEDER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign done       = r_done;
    assign result_num = r_result_num;
    assign result     = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        load   = 1'b0;
        d1     = '0;
        d1_num = '0;
        d2     = '0;
        d2_num = '0;
        w_sel  = '0;
        for (int k = 0; k < NUM_CLASS; k++) begin
            if (r_idx == 4'(k)) begin
                w_sel = r_score[k];
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                load   = 1'b1;
                d2     = w_sel;
                d2_num = r_idx;
                // First compare seeds with score 0; later compares chain the running max.
                if (r_idx == 4'd1) begin
                    d1     = r_score[0];
                    d1_num = 4'd0;
                end else begin
                    d1     = q;
                    d1_num = q_num;
                end
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (r_idx == C_LAST_IDX) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_result_num <= '0;
            r_result     <= '0;
            for (int k = 0; k < NUM_CLASS; k++) begin
                r_score[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx <= 4'd1;
                        for (int k = 0; k < NUM_CLASS; k++) begin
                            r_score[k] <= scores[k*DATA_LEN +: DATA_LEN];
                        end
                    end
                end
                ST_RUN: begin
                    r_idx <= r_idx + 4'd1;
                end
                ST_FINISH: begin
                    // An abort here wins over capture: previous result is kept.
                    if (!w_abort) begin
                        r_result     <= q;
                        r_result_num <= q_num;
                        r_done       <= 1'b1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
